exp6_unidade_controle: RTL

- Moore control unit for the Experiment 6 memory game, in which the player repeats a stored sequence that grows by one move each round.
- Sequences the game datapath: address counter E, round-limit counter L, move register R and level register N.
- Watches the datapath condition flags and owns an internal per-move timeout counter.
- Drives the result outputs and a 4-bit state code; the top level feeds that code to hexa7seg for display.

---
 rtl/exp6_pkg.sv | 26 ++
 rtl/exp6_contador_timeout.sv | 34 +++
 rtl/exp6_unidade_controle.sv | 131 +++++++++++++
 3 files changed

// File: rtl/exp6_pkg.sv
`default_nettype none
// ============================================================================
// exp6_pkg : shared state encodings and defaults for the Experiment 6 control unit
// Rev 1.0
// ============================================================================
package exp6_pkg;

    localparam int c_timeout_cycles = 5000;

    // Codes double as the db_estado display value
    typedef enum logic [3:0] {
        S_INICIAL        = 4'h0,
        S_PREPARACAO     = 4'h1,
        S_INICIA_RODADA  = 4'h2,
        S_ESPERA_JOGADA  = 4'h3,
        S_REGISTRA       = 4'h4,
        S_COMPARACAO     = 4'h5,
        S_PROXIMA_JOGADA = 4'h6,
        S_PROXIMA_RODADA = 4'h7,
        S_FIM_ACERTO     = 4'hA,
        S_FIM_TIMEOUT    = 4'hD,
        S_FIM_ERRO       = 4'hE
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/exp6_contador_timeout.sv
`default_nettype none
// ============================================================================
// exp6_contador_timeout : saturating per-move timer, fim at count M-1
// Rev 1.0
// ============================================================================
module exp6_contador_timeout #(
    parameter int M = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic conta,
    input  logic zera,
    output logic fim
);

    localparam int c_W = (M > 2) ? $clog2(M) : 1;

    logic [c_W-1:0] r_conta;

    assign fim = (r_conta == c_W'(M - 1));

    // Holds at M-1 so a late jogada can never see a wrapped count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_conta <= '0;
        end else if (zera) begin
            r_conta <= '0;
        end else if (conta && !fim) begin
            r_conta <= r_conta + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exp6_unidade_controle.sv
`default_nettype none
// ============================================================================
// exp6_unidade_controle : Moore control unit for the Experiment 6 memory game
// Rev 1.0
// ============================================================================
module exp6_unidade_controle
    import exp6_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_timeout_cycles
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       nivel,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    input  logic       meioL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       registraN,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;
    logic    w_espera;
    logic    w_fim_timeout;
    logic    w_ultima;

    assign w_espera = (r_estado == S_ESPERA_JOGADA);
    assign w_ultima = nivel ? fimL : meioL;

    exp6_contador_timeout #(
        .M (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .conta (w_espera),
        .zera  (!w_espera),
        .fim   (w_fim_timeout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= S_INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = S_INICIAL;
        case (r_estado)
            S_INICIAL:        w_proximo = iniciar ? S_PREPARACAO : S_INICIAL;
            S_PREPARACAO:     w_proximo = S_INICIA_RODADA;
            S_INICIA_RODADA:  w_proximo = S_ESPERA_JOGADA;
            // A move arriving on the expiry cycle still counts
            S_ESPERA_JOGADA: begin
                if (jogada)             w_proximo = S_REGISTRA;
                else if (w_fim_timeout) w_proximo = S_FIM_TIMEOUT;
                else                    w_proximo = S_ESPERA_JOGADA;
            end
            S_REGISTRA:       w_proximo = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!igual)         w_proximo = S_FIM_ERRO;
                else if (!fimE)     w_proximo = S_PROXIMA_JOGADA;
                else if (w_ultima)  w_proximo = S_FIM_ACERTO;
                else                w_proximo = S_PROXIMA_RODADA;
            end
            S_PROXIMA_JOGADA: w_proximo = S_ESPERA_JOGADA;
            S_PROXIMA_RODADA: w_proximo = S_INICIA_RODADA;
            S_FIM_ACERTO,
            S_FIM_ERRO,
            S_FIM_TIMEOUT:    w_proximo = iniciar ? S_PREPARACAO : r_estado;
            default:          w_proximo = S_INICIAL;
        endcase
    end

    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        registraN = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        pronto    = 1'b0;
        case (r_estado)
            S_PREPARACAO: begin
                zeraE     = 1'b1;
                zeraL     = 1'b1;
                zeraR     = 1'b1;
                registraN = 1'b1;
            end
            S_INICIA_RODADA:  zeraE     = 1'b1;
            S_REGISTRA:       registraR = 1'b1;
            S_PROXIMA_JOGADA: contaE    = 1'b1;
            S_PROXIMA_RODADA: contaL    = 1'b1;
            S_FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            S_FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            S_FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = r_estado;

endmodule
`default_nettype wire
